// File: rtl/fp32_pkg.sv
// Shared binary32 constants and field view used by the power-table datapath.
package fp32_pkg;

  localparam logic [31:0] FP32_ONE  = 32'h3F80_0000;
  localparam logic [31:0] FP32_QNAN = 32'h7FC0_0000;
  localparam logic [31:0] FP32_PINF = 32'h7F80_0000;

  localparam int unsigned N_POW = 50;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [22:0] frac;
  } fp32_t;

endpackage

// File: rtl/fp32_mul.sv
// Combinational binary32 multiplier: round-to-nearest-even, subnormals
// flushed to zero on input and output, canonical qNaN for invalid cases.
module fp32_mul
  import fp32_pkg::*;
(
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] y
);

  fp32_t fa;
  fp32_t fb;
  assign fa = a;
  assign fb = b;

  logic               sgn;
  logic               a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
  logic [47:0]        prod;
  logic [23:0]        mant;
  logic               guard, sticky, rnd;
  logic [24:0]        mant_r;
  logic [22:0]        frac_r;
  logic signed [9:0]  exp_n;

  // Special-case classification, significand product, rounding and packing.
  always_comb begin
    sgn    = fa.sign ^ fb.sign;
    a_zero = (fa.exp == 8'h00);
    b_zero = (fb.exp == 8'h00);
    a_inf  = (fa.exp == 8'hFF) && (fa.frac == '0);
    b_inf  = (fb.exp == 8'hFF) && (fb.frac == '0);
    a_nan  = (fa.exp == 8'hFF) && (fa.frac != '0);
    b_nan  = (fb.exp == 8'hFF) && (fb.frac != '0);

    prod = 48'({1'b1, fa.frac}) * 48'({1'b1, fb.frac});

    // Product lies in [1,4); pick the 24-bit window under the leading one.
    if (prod[47]) begin
      mant   = prod[47:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[46:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end

    exp_n = $signed({2'b00, fa.exp}) + $signed({2'b00, fb.exp}) - 10'sd127
          + (prod[47] ? 10'sd1 : 10'sd0);

    rnd    = guard & (sticky | mant[0]);
    mant_r = {1'b0, mant} + 25'(rnd);
    if (mant_r[24]) begin
      exp_n  = exp_n + 10'sd1;
      frac_r = mant_r[23:1];
    end else begin
      frac_r = mant_r[22:0];
    end

    if (a_nan || b_nan || (a_zero && b_inf) || (a_inf && b_zero)) begin
      y = FP32_QNAN;
    end else if (a_inf || b_inf) begin
      y = {sgn, FP32_PINF[30:0]};
    end else if (a_zero || b_zero) begin
      y = {sgn, 31'd0};
    end else if (exp_n >= 10'sd255) begin
      y = {sgn, FP32_PINF[30:0]};
    end else if (exp_n <= 10'sd0) begin
      y = {sgn, 31'd0};
    end else begin
      y = {sgn, exp_n[7:0], frac_r};
    end
  end

endmodule

// File: rtl/int_power.sv
// Iteratively fills out[k] = inputA^k using one shared binary32 multiplier.
// A change of inputA (or the first cycle after reset) restarts the table.
module int_power
  import fp32_pkg::*;
#(
  parameter int unsigned N_POW = fp32_pkg::N_POW,
  parameter int unsigned FP_W  = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [FP_W-1:0]             inputA,
  output logic [N_POW:0][FP_W-1:0]    out,
  output logic                        done
);

  localparam int unsigned   KW      = $clog2(N_POW + 2);
  localparam logic [KW-1:0] K_FIRST = KW'(2);
  localparam logic [KW-1:0] K_LAST  = KW'(N_POW);

  logic [FP_W-1:0]          a_q,     a_d;
  logic [KW-1:0]            k_q,     k_d;
  logic [N_POW:1][FP_W-1:0] out_q,   out_d;
  logic                     done_q,  done_d;
  logic                     first_q, first_d;

  logic [FP_W-1:0]          prev;
  logic [FP_W-1:0]          mul_y;

  assign out  = {out_q, FP32_ONE};
  assign done = done_q;

  // Select out[k-1] as the running product to multiply by the operand.
  always_comb begin
    prev = '0;
    for (int unsigned i = 1; i < N_POW; i++) begin
      if (k_q == KW'(i + 1)) prev = out_q[i];
    end
  end

  fp32_mul u_mul (
    .a (prev),
    .b (a_q),
    .y (mul_y)
  );

  // Restart on operand change or first post-reset cycle, else advance one power.
  always_comb begin
    a_d     = a_q;
    k_d     = k_q;
    out_d   = out_q;
    done_d  = done_q;
    first_d = 1'b0;
    if (first_q || (inputA != a_q)) begin
      a_d      = inputA;
      out_d[1] = inputA;
      k_d      = K_FIRST;
      done_d   = 1'b0;
    end else if (k_q <= K_LAST) begin
      for (int unsigned i = 2; i <= N_POW; i++) begin
        if (k_q == KW'(i)) out_d[i] = mul_y;
      end
      k_d = k_q + KW'(1);
      if (k_q == K_LAST) done_d = 1'b1;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      k_q     <= '0;
      out_q   <= '0;
      done_q  <= 1'b0;
      first_q <= 1'b1;
    end else begin
      a_q     <= a_d;
      k_q     <= k_d;
      out_q   <= out_d;
      done_q  <= done_d;
      first_q <= first_d;
    end
  end

endmodule

// File: tb/tb_int_power.sv
// Scoreboard bench for int_power: the driver pushes the expected power table
// for each operand that should run to completion; a monitor compares the table
// and the restart-to-done latency whenever done rises.
module tb_int_power;

  localparam logic [31:0] ONE = 32'h3F80_0000;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [31:0]        inputA = '0;
  logic [50:0][31:0]  out_w;
  logic               done;

  int unsigned cyc    = 0;
  int unsigned n_cmp  = 0;
  int unsigned n_fail = 0;

  typedef struct packed {
    logic [31:0]       op;
    logic [50:0][31:0] vals;
    logic [31:0]       start;
  } exp_t;

  exp_t sb_q[$];

  int_power #(.N_POW(50), .FP_W(32)) dut (
    .clk    (clk),
    .rst    (rst),
    .inputA (inputA),
    .out    (out_w),
    .done   (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference binary32 multiply from the arithmetic rules: exact integer
  // product, divide down to 24 significant bits, round the remainder to even.
  function automatic logic [31:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
    logic        s;
    logic        xz, yz, xi, yi, xn, yn;
    logic [63:0] m, q, r, half;
    int          sh, e;
    s  = x[31] ^ y[31];
    xz = (x[30:23] == 8'd0);   yz = (y[30:23] == 8'd0);
    xi = (x[30:23] == 8'd255) && (x[22:0] == 23'd0);
    yi = (y[30:23] == 8'd255) && (y[22:0] == 23'd0);
    xn = (x[30:23] == 8'd255) && (x[22:0] != 23'd0);
    yn = (y[30:23] == 8'd255) && (y[22:0] != 23'd0);
    if (xn || yn)                 return 32'h7FC0_0000;
    if ((xi && yz) || (yi && xz)) return 32'h7FC0_0000;
    if (xi || yi)                 return {s, 31'h7F80_0000};
    if (xz || yz)                 return {s, 31'd0};
    m    = 64'({1'b1, x[22:0]}) * 64'({1'b1, y[22:0]});
    sh   = (m >= (64'd1 << 47)) ? 24 : 23;
    q    = m >> sh;
    r    = m - (q << sh);
    half = 64'd1 << (sh - 1);
    if ((r > half) || ((r == half) && (q % 2 == 1))) q = q + 1;
    e = int'(x[30:23]) + int'(y[30:23]) + sh - 150;
    if (q == (64'd1 << 24)) begin
      q = q >> 1;
      e = e + 1;
    end
    if (e >= 255) return {s, 31'h7F80_0000};
    if (e <= 0)   return {s, 31'd0};
    return {s, e[7:0], q[22:0]};
  endfunction

  function automatic exp_t build(input logic [31:0] v, input logic [31:0] start);
    exp_t t;
    t.op      = v;
    t.start   = start;
    t.vals[0] = ONE;
    t.vals[1] = v;
    for (int k = 2; k <= 50; k++) t.vals[k] = ref_mul(t.vals[k-1], v);
    return t;
  endfunction

  // Monitor: on each rising edge of done, pop and compare the whole table.
  initial begin : monitor
    logic dprev;
    exp_t t;
    dprev = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst && (done === 1'b1) && !dprev) begin
        if (sb_q.size() == 0) begin
          n_cmp++; n_fail++;
          $display("FAIL unexpected_done at cycle %0d: got done=1 want no completion", cyc);
        end else begin
          t = sb_q.pop_front();
          for (int k = 0; k <= 50; k++) begin
            n_cmp++;
            if (out_w[k] !== t.vals[k]) begin
              n_fail++;
              $display("FAIL out[%0d] op=%h: got %h want %h", k, t.op, out_w[k], t.vals[k]);
            end
          end
          n_cmp++;
          if ((cyc - t.start) != 49) begin
            n_fail++;
            $display("FAIL latency op=%h: got %0d want 49", t.op, cyc - t.start);
          end
        end
      end
      dprev = (done === 1'b1);
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  // Apply a new operand; one cycle after the restart edge done must be low
  // and out[1] must already hold the operand.
  task automatic issue(input logic [31:0] v, input bit expect_done);
    @(negedge clk);
    inputA = v;
    if (expect_done) sb_q.push_back(build(v, cyc + 1));
    @(negedge clk);
    chk("done_low_after_restart", {31'd0, done}, 32'd0);
    chk("out1_after_restart", out_w[1], v);
  endtask

  task automatic drain();
    int unsigned n;
    n = 0;
    while ((sb_q.size() != 0) && (n < 150)) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() != 0) begin
      n_cmp++; n_fail++;
      $display("FAIL done_timeout: got %0d pending want 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic check_reset_state(input string name);
    chk({name, "_out0"}, out_w[0], ONE);
    chk({name, "_done"}, {31'd0, done}, 32'd0);
    for (int k = 1; k <= 50; k++) chk({name, "_outk"}, out_w[k], 32'd0);
  endtask

  initial begin : driver
    logic [31:0] v, last;

    // Reset with operand 0.0: only the forced post-reset restart starts a run.
    inputA = 32'h0000_0000;
    rst    = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_state("reset");
    rst = 1'b0;
    sb_q.push_back(build(32'h0000_0000, cyc + 1));
    drain();
    chk("zero_out0", out_w[0], ONE);
    chk("zero_out1", out_w[1], 32'h0);
    chk("zero_out50", out_w[50], 32'h0);

    issue(32'h4000_0000, 1'b1); drain();
    chk("two_p0", out_w[0], 32'h3F80_0000);
    chk("two_p1", out_w[1], 32'h4000_0000);
    chk("two_p2", out_w[2], 32'h4080_0000);
    chk("two_p3", out_w[3], 32'h4100_0000);
    chk("two_p10", out_w[10], 32'h4480_0000);
    chk("two_p50", out_w[50], 32'h5880_0000);
    chk("two_done_hold", {31'd0, done}, 32'd1);

    issue(32'h4040_0000, 1'b1); drain();
    chk("three_p2", out_w[2], 32'h4110_0000);
    chk("three_p3", out_w[3], 32'h41D8_0000);

    issue(32'h4020_0000, 1'b1); drain();
    chk("twohalf_p2", out_w[2], 32'h40C8_0000);
    chk("twohalf_p3", out_w[3], 32'h417A_0000);

    issue(32'hC000_0000, 1'b1); drain();
    chk("negtwo_p2", out_w[2], 32'h4080_0000);
    chk("negtwo_p3", out_w[3], 32'hC100_0000);

    issue(32'h4180_0000, 1'b1); drain();
    chk("sixteen_p31", out_w[31], 32'h7D80_0000);
    chk("sixteen_p32", out_w[32], 32'h7F80_0000);
    chk("sixteen_p50", out_w[50], 32'h7F80_0000);

    issue(32'h7FC0_0001, 1'b1); drain();
    chk("nan_p2", out_w[2], 32'h7FC0_0000);
    chk("nan_p50", out_w[50], 32'h7FC0_0000);

    // Operand changes mid-run: the first run never completes.
    issue(32'h3FC0_0000, 1'b0);
    repeat (18) @(negedge clk);
    issue(32'h3FA0_0000, 1'b1); drain();

    // Rewriting the current operand mid-run is not a restart.
    issue(32'h3F40_0000, 1'b1);
    repeat (10) @(negedge clk);
    inputA = 32'h3F40_0000;
    drain();

    // Reset mid-run, then recompute for the still-applied operand.
    issue(32'h4040_0000, 1'b0);
    repeat (15) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    check_reset_state("midrst");
    rst = 1'b0;
    sb_q.push_back(build(32'h4040_0000, cyc + 1));
    drain();

    // Random operands: mostly near 1.0 so tables stay finite for many powers.
    last = 32'h4040_0000;
    for (int i = 0; i < 14; i++) begin
      do begin
        if ($urandom_range(0, 3) == 0) v = $urandom;
        else v = {1'($urandom_range(0, 1)), 8'(124 + $urandom_range(0, 6)), 23'($urandom)};
      end while (v == last);
      last = v;
      issue(v, 1'b1);
      drain();
    end

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
